operand_issue_stage: RTL and testbench
======================================

Name: operand_issue_stage

Overview:
- Register-file and operand stage that sits directly upstream of the function unit.
- Accepts one control word per cycle, reads two source registers, and applies the constant/register B-mux.
- Registers the operands, function select and shift amount, then presents them to the function unit one cycle later.
- Writes the function unit's result back to the destination register, latches the V/C/N/Z status flags, and forwards results to a back-to-back dependent instruction.

Parameters:
- DATA_W, 32, operand/result width; matches the function unit datapath.
- ADDR_W, 3, register address width; register count is 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  control word present this cycle.
- issue_ready  out  1  stage can accept; equals !stall.
- sa  in  ADDR_W  A source register.
- sb  in  ADDR_W  B source register.
- mb  in  1  B select: 1 = const_in, 0 = register sb.
- const_in  in  DATA_W  immediate operand.
- fs_in  in  4  function select passed to the function unit.
- sh_in  in  5  shift amount passed to the function unit.
- dest  in  ADDR_W  destination register.
- wr_en  in  1  instruction writes dest.
- st_ld  in  1  instruction loads the status register.
- stall  in  1  downstream hold.
- fu_valid  out  1  operands at the function unit are live.
- fu_fs  out  4  registered function select.
- fu_sh  out  5  registered shift amount.
- fu_a  out  DATA_W  registered A operand.
- fu_b  out  DATA_W  registered B operand.
- wb_data  in  DATA_W  function unit result (fout), combinational return.
- wb_v, wb_c, wb_n, wb_z  in  1 each  function unit flags.
- st_v, st_c, st_n, st_z  out  1 each  latched status flags.

Behaviour:
- Reset (async, while rst=1):
  - all registers = 0.
  - fu_valid = 0; fu_fs = 0; fu_sh = 0; fu_a = 0; fu_b = 0.
  - status flags = 0.
  - pending wr_en/st_ld/dest = 0.
  - An instruction in flight is discarded; no writeback occurs.
- Acceptance: an instruction is accepted on a rising edge with issue_valid=1 and stall=0. Next cycle:
  - fu_valid=1.
  - fu_a = R[sa].
  - fu_b = mb ? const_in : R[sb].
  - fu_fs = fs_in; fu_sh = sh_in.
  - dest, wr_en, st_ld are stored alongside.
- Empty cycle: issue_valid=0 with stall=0 gives fu_valid=0 next cycle. Operand registers hold their old values.
- Retirement: a live instruction (fu_valid=1, stall=0) retires at the rising edge.
  - If its wr_en=1: R[dest] <= wb_data.
  - If its st_ld=1: {st_v, st_c, st_n, st_z} <= {wb_v, wb_c, wb_n, wb_z}.
  - Latency is issue -> operands: 1 cycle; issue -> register/status update: 2 edges.
- Stall=1:
  - Operand registers, fu_valid and pending control hold.
  - No writeback, no status load, no acceptance.
  - issue_ready=0.
- Forwarding: when the retiring instruction writes register X and the instruction being accepted in the same edge reads X, the operand takes wb_data, not the stale R[X].
  - Applies to sa always.
  - Applies to sb only when mb=0.
  - If sa=sb=X, both operands are forwarded.
- Multiple reads: simultaneous reads of the same register are permitted. One write per cycle.
- Wrap-around: none. Addresses are exact-width.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to zero; writes to it are discarded.
  - Forwarding never applies to address 0; reads of R0 return 0.
- Undefined: R0 is an ordinary register.

Decomposition:
- Shared package holds:
  - the function-select encodings FS_* for 0000..1111 (transfer, inc, add, add+1, a+~b, sub, dec, and, or, xor, not, pass-B, srl, sll, zero);
  - DATA_W/ADDR_W defaults;
  - a status-flag struct {v, c, n, z}.
- Sub-module regfile_2r1w: two asynchronous read ports, one synchronous write port, and the R0 option.
- Forwarding, the B-mux, and the pipeline/status registers stay in the top level.

Test Plan:
- Reset mid-flight: issue add with wr_en, assert rst before retirement -> fu_valid=0, R[dest]=0, status=0.
- Issue (const_in=5, mb=1, fs=pass-B, dest=1, wr_en); then issue (sa=1, mb=1, const_in=3, fs=add, dest=2) back-to-back -> fu_a=5 via forwarding; R2=8 after retirement.
- R1=0x7FFFFFFF and R2=1, issue add with st_ld=1 -> st_v=1, st_n=1, st_c=0, st_z=0.
- Hold stall for 3 cycles with a live sub -> fu_a/fu_b/fu_fs unchanged, issue_ready=0, no register write; on release, exactly one write.
- sa=sb=3 with previous instruction writing R3=0xA5 -> fu_a=fu_b=0xA5.
- With REGFILE_R0_ZERO_EN, write 0xFFFF to R0 then read sa=0 -> fu_a=0, including in the back-to-back forwarding case.

Source files
------------

// File: rtl/operand_issue_stage_pkg.sv
// Shared types for the operand issue stage: function-select codes, width defaults, status flags.
// Function-select codes are what fu_fs carries to the function unit.
// No logic here; imported by the stage top and its register file.
package operand_issue_stage_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 3;

  typedef enum logic [3:0] {
    FS_TSF_A   = 4'b0000,  // F = A
    FS_INC     = 4'b0001,  // F = A + 1
    FS_ADD     = 4'b0010,  // F = A + B
    FS_ADD_INC = 4'b0011,  // F = A + B + 1
    FS_ADD_NB  = 4'b0100,  // F = A + ~B
    FS_SUB     = 4'b0101,  // F = A + ~B + 1
    FS_DEC     = 4'b0110,  // F = A - 1
    FS_TSF_A2  = 4'b0111,  // F = A (alias)
    FS_AND     = 4'b1000,
    FS_OR      = 4'b1001,
    FS_XOR     = 4'b1010,
    FS_NOT     = 4'b1011,
    FS_PASS_B  = 4'b1100,  // F = B
    FS_SRL     = 4'b1101,
    FS_SLL     = 4'b1110,
    FS_ZERO    = 4'b1111
  } fs_e;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } status_t;

endpackage

// File: rtl/operand_issue_stage_regfile_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Latency: reads combinational, write visible after the clock edge.
// Optional REGFILE_R0_ZERO_EN: R0 reads as zero and ignores writes.
module regfile_2r1w #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              wr_ok;

`ifdef REGFILE_R0_ZERO_EN
  assign wr_ok   = (wa != '0);
  assign ra_data = (ra_addr == '0) ? '0 : regs_q[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs_q[rb_addr];
`else
  assign wr_ok   = 1'b1;
  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];
`endif

  // Next-state of the array: at most one entry changes per cycle.
  always_comb begin
    regs_d = regs_q;
    if (we && wr_ok) regs_d[wa] = wd;
  end

  // Storage; reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

endmodule

// File: rtl/operand_issue_stage.sv
// Operand issue stage: reads sources, applies B-mux and forwarding, registers operands for the FU.
// Latency: issue -> fu_* outputs 1 cycle; issue -> register/status update 2 edges.
// Backpressure: stall holds all stage state and blocks accept/retire; REGFILE_R0_ZERO_EN hardwires R0.
module operand_issue_stage
  import operand_issue_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] sa,
  input  logic [ADDR_W-1:0] sb,
  input  logic              mb,
  input  logic [DATA_W-1:0] const_in,
  input  logic [3:0]        fs_in,
  input  logic [4:0]        sh_in,
  input  logic [ADDR_W-1:0] dest,
  input  logic              wr_en,
  input  logic              st_ld,
  input  logic              stall,
  output logic              fu_valid,
  output logic [3:0]        fu_fs,
  output logic [4:0]        fu_sh,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_v,
  input  logic              wb_c,
  input  logic              wb_n,
  input  logic              wb_z,
  output logic              st_v,
  output logic              st_c,
  output logic              st_n,
  output logic              st_z
);

  logic              fu_valid_q, fu_valid_d;
  logic [3:0]        fu_fs_q, fu_fs_d;
  logic [4:0]        fu_sh_q, fu_sh_d;
  logic [DATA_W-1:0] fu_a_q, fu_a_d;
  logic [DATA_W-1:0] fu_b_q, fu_b_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic              wr_en_q, wr_en_d;
  logic              st_ld_q, st_ld_d;
  status_t           status_q, status_d;

  logic              retire, accept, rf_we;
  logic              fwd_a, fwd_b;
  logic [DATA_W-1:0] rd_a, rd_b, op_a, op_b;

  assign retire = fu_valid_q & ~stall;
  assign accept = issue_valid & ~stall;
  assign rf_we  = retire & wr_en_q;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (sa),
    .ra_data (rd_a),
    .rb_addr (sb),
    .rb_data (rd_b),
    .we      (rf_we),
    .wa      (dest_q),
    .wd      (wb_data)
  );

  // The retiring result is not yet in the array when a dependent instruction reads it.
`ifdef REGFILE_R0_ZERO_EN
  assign fwd_a = rf_we && (dest_q == sa) && (sa != '0);
  assign fwd_b = rf_we && (dest_q == sb) && (sb != '0);
`else
  assign fwd_a = rf_we && (dest_q == sa);
  assign fwd_b = rf_we && (dest_q == sb);
`endif

  assign op_a = fwd_a ? wb_data : rd_a;
  assign op_b = mb ? const_in : (fwd_b ? wb_data : rd_b);

  // Pipeline and status next-state: hold on stall, load operands only on accept.
  always_comb begin
    fu_valid_d = fu_valid_q;
    fu_fs_d    = fu_fs_q;
    fu_sh_d    = fu_sh_q;
    fu_a_d     = fu_a_q;
    fu_b_d     = fu_b_q;
    dest_d     = dest_q;
    wr_en_d    = wr_en_q;
    st_ld_d    = st_ld_q;
    status_d   = status_q;
    if (!stall) fu_valid_d = issue_valid;
    if (accept) begin
      fu_fs_d = fs_in;
      fu_sh_d = sh_in;
      fu_a_d  = op_a;
      fu_b_d  = op_b;
      dest_d  = dest;
      wr_en_d = wr_en;
      st_ld_d = st_ld;
    end
    if (retire && st_ld_q) status_d = {wb_v, wb_c, wb_n, wb_z};
  end

  // Stage registers; reset discards any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fu_valid_q <= 1'b0;
      fu_fs_q    <= '0;
      fu_sh_q    <= '0;
      fu_a_q     <= '0;
      fu_b_q     <= '0;
      dest_q     <= '0;
      wr_en_q    <= 1'b0;
      st_ld_q    <= 1'b0;
      status_q   <= '0;
    end else begin
      fu_valid_q <= fu_valid_d;
      fu_fs_q    <= fu_fs_d;
      fu_sh_q    <= fu_sh_d;
      fu_a_q     <= fu_a_d;
      fu_b_q     <= fu_b_d;
      dest_q     <= dest_d;
      wr_en_q    <= wr_en_d;
      st_ld_q    <= st_ld_d;
      status_q   <= status_d;
    end
  end

  assign issue_ready = ~stall;
  assign fu_valid    = fu_valid_q;
  assign fu_fs       = fu_fs_q;
  assign fu_sh       = fu_sh_q;
  assign fu_a        = fu_a_q;
  assign fu_b        = fu_b_q;
  assign st_v        = status_q.v;
  assign st_c        = status_q.c;
  assign st_n        = status_q.n;
  assign st_z        = status_q.z;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage with a small function-unit model driving the writeback.
// Expected operands are queued at issue and popped when fu_valid presents them.
// Build with REGFILE_R0_ZERO_EN defined to exercise the hardwired-R0 variant.
module tb_operand_issue_stage;
  import operand_issue_stage_pkg::*;

`ifdef REGFILE_R0_ZERO_EN
  localparam logic [31:0] R0_EXP = 32'h0;
`else
  localparam logic [31:0] R0_EXP = 32'h0000_FFFF;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [2:0]  sa, sb, dest;
  logic        mb, wr_en, st_ld, stall;
  logic [31:0] const_in;
  logic [3:0]  fs_in;
  logic [4:0]  sh_in;
  logic        fu_valid;
  logic [3:0]  fu_fs;
  logic [4:0]  fu_sh;
  logic [31:0] fu_a, fu_b;
  logic [31:0] wb_data;
  logic        wb_v, wb_c, wb_n, wb_z;
  logic        st_v, st_c, st_n, st_z;

  always #5 clk = ~clk;

  operand_issue_stage #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .sa(sa), .sb(sb), .mb(mb), .const_in(const_in),
    .fs_in(fs_in), .sh_in(sh_in), .dest(dest),
    .wr_en(wr_en), .st_ld(st_ld), .stall(stall),
    .fu_valid(fu_valid), .fu_fs(fu_fs), .fu_sh(fu_sh),
    .fu_a(fu_a), .fu_b(fu_b),
    .wb_data(wb_data), .wb_v(wb_v), .wb_c(wb_c), .wb_n(wb_n), .wb_z(wb_z),
    .st_v(st_v), .st_c(st_c), .st_n(st_n), .st_z(st_z)
  );

  // Function unit model: only the operations the sequence uses.
  logic [32:0] sum;
  always_comb begin
    sum  = '0;
    wb_c = 1'b0;
    wb_v = 1'b0;
    case (fu_fs)
      FS_ADD: begin
        sum  = {1'b0, fu_a} + {1'b0, fu_b};
        wb_c = sum[32];
        wb_v = (fu_a[31] == fu_b[31]) && (sum[31] != fu_a[31]);
      end
      FS_SUB: begin
        sum  = {1'b0, fu_a} + {1'b0, ~fu_b} + 33'd1;
        wb_c = sum[32];
        wb_v = (fu_a[31] != fu_b[31]) && (sum[31] != fu_a[31]);
      end
      FS_TSF_A:  sum = {1'b0, fu_a};
      FS_PASS_B: sum = {1'b0, fu_b};
      default:   sum = '0;
    endcase
    wb_data = sum[31:0];
    wb_n    = wb_data[31];
    wb_z    = (wb_data == 32'h0);
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  fs;
    logic [4:0]  sh;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic v, c, n, z);
    chk(tag, 32'({st_v, st_c, st_n, st_z}), 32'({v, c, n, z}));
  endtask

  task automatic check_out();
    exp_t e;
    chk("fu_valid", 32'(fu_valid), 32'd1);
    chk("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("fu_a",  fu_a, e.a);
      chk("fu_b",  fu_b, e.b);
      chk("fu_fs", 32'(fu_fs), 32'(e.fs));
      chk("fu_sh", 32'(fu_sh), 32'(e.sh));
    end
  endtask

  task automatic issue(input logic [2:0] a_s, input logic [2:0] b_s, input logic m,
                       input logic [31:0] c, input logic [3:0] fs, input logic [2:0] d,
                       input logic w, input logic s, input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    issue_valid = 1'b1;
    stall       = 1'b0;
    sa          = a_s;
    sb          = b_s;
    mb          = m;
    const_in    = c;
    fs_in       = fs;
    sh_in       = {2'b00, d} + 5'd7;
    dest        = d;
    wr_en       = w;
    st_ld       = s;
    e.a = ea; e.b = eb; e.fs = fs; e.sh = sh_in;
    sb_q.push_back(e);
    tick();
    check_out();
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    stall       = 1'b0;
    tick();
    chk("fu_valid_idle", 32'(fu_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; stall = 1'b0; sa = '0; sb = '0; mb = 1'b0;
    const_in = '0; fs_in = '0; sh_in = '0; dest = '0; wr_en = 1'b0; st_ld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fu_valid", 32'(fu_valid), 32'd0);
    chk("rst_fu_a", fu_a, 32'd0);
    chk("rst_fu_b", fu_b, 32'd0);
    chk("rst_fu_fs", 32'(fu_fs), 32'd0);
    chk("rst_fu_sh", 32'(fu_sh), 32'd0);
    check_status("rst_status", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);

    // Reset while an add to R4 is in flight: it must never retire.
    issue(3'd0, 3'd0, 1'b1, 32'h8000_0000, FS_ADD, 3'd4, 1'b1, 1'b1, 32'h0, 32'h8000_0000);
    #2 rst = 1'b1;
    #1;
    chk("midrst_fu_valid", 32'(fu_valid), 32'd0);
    chk("midrst_fu_b", fu_b, 32'd0);
    check_status("midrst_status", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    issue(3'd4, 3'd4, 1'b0, 32'h0, FS_TSF_A, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Back-to-back dependency through sa; then read the retired sum.
    issue(3'd0, 3'd0, 1'b1, 32'd5, FS_PASS_B, 3'd1, 1'b1, 1'b0, 32'h0, 32'd5);
    issue(3'd1, 3'd0, 1'b1, 32'd3, FS_ADD,    3'd2, 1'b1, 1'b0, 32'd5, 32'd3);
    idle();
    issue(3'd2, 3'd1, 1'b0, 32'h0, FS_TSF_A, 3'd0, 1'b0, 1'b0, 32'd8, 32'd5);

    // Signed overflow on add; sb forwarded from the previous write of R2.
    issue(3'd0, 3'd0, 1'b1, 32'h7FFF_FFFF, FS_PASS_B, 3'd1, 1'b1, 1'b0, 32'h0, 32'h7FFF_FFFF);
    issue(3'd0, 3'd0, 1'b1, 32'h1,         FS_PASS_B, 3'd2, 1'b1, 1'b0, 32'h0, 32'h1);
    issue(3'd1, 3'd2, 1'b0, 32'h0,         FS_ADD,    3'd3, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h1);
    idle();
    check_status("st_add_ovf", 1'b1, 1'b0, 1'b1, 1'b0);

    // Live sub held by three stall cycles while another issue is offered.
    issue(3'd1, 3'd2, 1'b0, 32'h0, FS_SUB, 3'd5, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h1);
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; stall = 1'b1;
      sa = 3'd0; mb = 1'b1; const_in = 32'hDEAD; fs_in = FS_PASS_B; dest = 3'd7;
      #1;
      chk("stall_issue_ready", 32'(issue_ready), 32'd0);
      tick();
      chk("stall_fu_valid", 32'(fu_valid), 32'd1);
      chk("stall_fu_a", fu_a, 32'h7FFF_FFFF);
      chk("stall_fu_b", fu_b, 32'h1);
      chk("stall_fu_fs", 32'(fu_fs), 32'(FS_SUB));
      check_status("stall_status", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    // Release: sub retires into R5 and both operands of the reader forward.
    issue(3'd5, 3'd5, 1'b0, 32'h0, FS_TSF_A, 3'd0, 1'b0, 1'b0, 32'h7FFF_FFFE, 32'h7FFF_FFFE);
    check_status("st_sub", 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    issue(3'd5, 3'd0, 1'b0, 32'h0, FS_TSF_A, 3'd0, 1'b0, 1'b0, 32'h7FFF_FFFE, 32'h0);

    // sa = sb = 3 right after the write of R3.
    issue(3'd0, 3'd0, 1'b1, 32'hA5, FS_PASS_B, 3'd3, 1'b1, 1'b0, 32'h0, 32'hA5);
    issue(3'd3, 3'd3, 1'b0, 32'h0,  FS_TSF_A,  3'd0, 1'b0, 1'b0, 32'hA5, 32'hA5);

    // mb=1 takes the constant even when sb matches the retiring dest.
    issue(3'd0, 3'd0, 1'b1, 32'h11, FS_PASS_B, 3'd6, 1'b1, 1'b0, 32'h0, 32'h11);
    issue(3'd0, 3'd6, 1'b1, 32'h22, FS_PASS_B, 3'd0, 1'b0, 1'b0, 32'h0, 32'h22);

    // Write R0, read it back-to-back and again after retirement.
    issue(3'd0, 3'd0, 1'b1, 32'hFFFF, FS_PASS_B, 3'd0, 1'b1, 1'b0, 32'h0, 32'hFFFF);
    issue(3'd0, 3'd0, 1'b0, 32'h0,    FS_TSF_A,  3'd0, 1'b0, 1'b0, R0_EXP, R0_EXP);
    idle();
    issue(3'd0, 3'd0, 1'b0, 32'h0,    FS_TSF_A,  3'd0, 1'b0, 1'b0, R0_EXP, R0_EXP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
